// File: rtl/axi_mem_arbiter_pkg.sv
// Shared types and defaults for the IF/MEM arbiter in front of the AXI bridge.
package axi_mem_arbiter_pkg;

    localparam int ADDR_W_DEF = 64;
    localparam int DATA_W_DEF = 64;
    localparam int LEN_W_DEF  = 8;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        SIZE_1B = 2'b00,
        SIZE_2B = 2'b01,
        SIZE_4B = 2'b10,
        SIZE_8B = 2'b11
    } size_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_IF_AR,
        S_IF_R,
        S_MEM_AR,
        S_MEM_R,
        S_MEM_W
    } state_t;

endpackage

// File: rtl/axi_mem_arbiter_if.sv
// Requester and bridge-side signal bundle; slave = arbiter, master = surroundings.
interface axi_mem_arbiter_if #(
    parameter int ADDR_W = axi_mem_arbiter_pkg::ADDR_W_DEF,
    parameter int DATA_W = axi_mem_arbiter_pkg::DATA_W_DEF,
    parameter int LEN_W  = axi_mem_arbiter_pkg::LEN_W_DEF
);
    logic              if_req_valid;
    logic [ADDR_W-1:0] if_req_addr;
    logic [LEN_W-1:0]  if_req_len;
    logic [1:0]        if_req_size;
    logic              if_req_ready;
    logic              if_resp_valid;
    logic [DATA_W-1:0] if_resp_data;
    logic              if_resp_last;
    logic              if_resp_err;

    logic              mem_req_valid;
    logic              mem_req_wr;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [LEN_W-1:0]  mem_req_len;
    logic [1:0]        mem_req_size;
    logic [DATA_W-1:0] mem_req_wdata;
    logic              mem_req_ready;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_data;
    logic              mem_resp_last;
    logic              mem_resp_err;

    logic              bus_ar_valid;
    logic              bus_aw_valid;
    logic [ADDR_W-1:0] bus_addr;
    logic [LEN_W-1:0]  bus_len;
    logic [1:0]        bus_size;
    logic [DATA_W-1:0] bus_data;
    logic              bus_ar_ready;
    logic              bus_r_valid;
    logic [DATA_W-1:0] bus_r_data;
    logic [1:0]        bus_resp;
    logic              bus_aw_ready;

    modport slave (
        input  if_req_valid, if_req_addr, if_req_len, if_req_size,
        output if_req_ready, if_resp_valid, if_resp_data, if_resp_last, if_resp_err,
        input  mem_req_valid, mem_req_wr, mem_req_addr, mem_req_len, mem_req_size, mem_req_wdata,
        output mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_last, mem_resp_err,
        output bus_ar_valid, bus_aw_valid, bus_addr, bus_len, bus_size, bus_data,
        input  bus_ar_ready, bus_r_valid, bus_r_data, bus_resp, bus_aw_ready
    );

    modport master (
        output if_req_valid, if_req_addr, if_req_len, if_req_size,
        input  if_req_ready, if_resp_valid, if_resp_data, if_resp_last, if_resp_err,
        output mem_req_valid, mem_req_wr, mem_req_addr, mem_req_len, mem_req_size, mem_req_wdata,
        input  mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_last, mem_resp_err,
        input  bus_ar_valid, bus_aw_valid, bus_addr, bus_len, bus_size, bus_data,
        output bus_ar_ready, bus_r_valid, bus_r_data, bus_resp, bus_aw_ready
    );

endinterface

// File: rtl/axi_mem_arbiter.sv
// Serialises IF and MEM requests onto the bridge's single cpu-side port, one
// transaction in flight, round-robin between the two requesters.
module axi_mem_arbiter
    import axi_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    axi_mem_arbiter_if.slave io
);

    state_t            state_q, state_d;
    logic              last_was_mem_q;
    logic [LEN_W-1:0]  beat_cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [1:0]        size_q;
    logic [DATA_W-1:0] data_q;

    logic grant_if;
    logic grant_mem;
    logic beat_acc;
    logic beat_last;
    logic resp_err;

    assign beat_last = (beat_cnt_q == len_q);
    assign resp_err  = (io.bus_resp != RESP_OKAY);

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // through the case can leave it unassigned and infer a latch.
        state_d           = state_q;
        grant_if          = 1'b0;
        grant_mem         = 1'b0;
        beat_acc          = 1'b0;
        io.if_req_ready   = 1'b0;
        io.mem_req_ready  = 1'b0;
        io.if_resp_valid  = 1'b0;
        io.if_resp_data   = '0;
        io.if_resp_last   = 1'b0;
        io.if_resp_err    = 1'b0;
        io.mem_resp_valid = 1'b0;
        io.mem_resp_data  = '0;
        io.mem_resp_last  = 1'b0;
        io.mem_resp_err   = 1'b0;
        io.bus_ar_valid   = 1'b0;
        io.bus_aw_valid   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // Gating with reset_n keeps the ready pulses quiet while reset is held.
                if (reset_n) begin
                    if (io.if_req_valid && (!io.mem_req_valid || last_was_mem_q)) begin
                        grant_if = 1'b1;
                        state_d  = S_IF_AR;
                    end else if (io.mem_req_valid) begin
                        grant_mem = 1'b1;
                        state_d   = io.mem_req_wr ? S_MEM_W : S_MEM_AR;
                    end
                end
                io.if_req_ready  = grant_if;
                io.mem_req_ready = grant_mem;
            end
            S_IF_AR: begin
                io.bus_ar_valid = 1'b1;
                if (io.bus_ar_ready) state_d = S_IF_R;
            end
            S_MEM_AR: begin
                io.bus_ar_valid = 1'b1;
                if (io.bus_ar_ready) state_d = S_MEM_R;
            end
            S_IF_R: begin
                if (io.bus_r_valid) begin
                    beat_acc         = 1'b1;
                    io.if_resp_valid = 1'b1;
                    io.if_resp_data  = io.bus_r_data;
                    io.if_resp_last  = beat_last;
                    io.if_resp_err   = resp_err;
                    if (beat_last) state_d = S_IDLE;
                end
            end
            S_MEM_R: begin
                if (io.bus_r_valid) begin
                    beat_acc          = 1'b1;
                    io.mem_resp_valid = 1'b1;
                    io.mem_resp_data  = io.bus_r_data;
                    io.mem_resp_last  = beat_last;
                    io.mem_resp_err   = resp_err;
                    if (beat_last) state_d = S_IDLE;
                end
            end
            S_MEM_W: begin
                io.bus_aw_valid = 1'b1;
                if (io.bus_aw_ready) begin
                    io.mem_resp_valid = 1'b1;
                    io.mem_resp_last  = 1'b1;
                    io.mem_resp_err   = resp_err;
                    state_d           = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_was_mem_q <= 1'b0;
            beat_cnt_q     <= '0;
            addr_q         <= '0;
            len_q          <= '0;
            size_q         <= '0;
            data_q         <= '0;
        end else if (grant_if) begin
            last_was_mem_q <= 1'b0;
            beat_cnt_q     <= '0;
            addr_q         <= io.if_req_addr;
            len_q          <= io.if_req_len;
            size_q         <= io.if_req_size;
            data_q         <= '0;
        end else if (grant_mem) begin
            last_was_mem_q <= 1'b1;
            beat_cnt_q     <= '0;
            addr_q         <= io.mem_req_addr;
            len_q          <= io.mem_req_wr ? '0 : io.mem_req_len;
            size_q         <= io.mem_req_size;
            data_q         <= io.mem_req_wdata;
        end else if (beat_acc) begin
            beat_cnt_q     <= beat_cnt_q + LEN_W'(1);
        end
    end

    assign io.bus_addr = addr_q;
    assign io.bus_len  = len_q;
    assign io.bus_size = size_q;
    assign io.bus_data = data_q;

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Directed bench for axi_mem_arbiter: a bridge model serves transactions while a
// monitor pops expected grants/responses from scoreboard queues.
module tb_axi_mem_arbiter;
    import axi_mem_arbiter_pkg::*;

    localparam int GR_IF  = 1;
    localparam int GR_MEM = 2;

    typedef struct packed {
        logic [63:0] data;
        logic        last;
        logic        err;
    } resp_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    axi_mem_arbiter_if bus_if ();

    axi_mem_arbiter dut (
        .clk     (clk),
        .reset_n (reset_n),
        .io      (bus_if)
    );

    int    checks   = 0;
    int    failures = 0;
    int    cyc      = 0;
    int    if_beats = 0;
    resp_t if_q [$];
    resp_t mem_q [$];
    int    grant_q [$];

    // Bridge model configuration and captured request fields
    logic        use_tab;
    logic [63:0] rtab [4];
    logic [15:0] err_mask;
    int          aw_delay;
    logic [63:0] cap_addr, cap_data;
    logic [7:0]  cap_len;
    logic [1:0]  cap_size;
    int          cap_cyc;
    int          grant_cyc_if;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic void push_if(input logic [63:0] d, input logic l, input logic e);
        if_q.push_back('{data: d, last: l, err: e});
    endfunction

    function automatic void push_mem(input logic [63:0] d, input logic l, input logic e);
        mem_q.push_back('{data: d, last: l, err: e});
    endfunction

    // Monitor: compares every grant pulse and response beat against the queues.
    initial begin : monitor
        resp_t e;
        forever begin
            @(negedge clk);
            if (bus_if.if_req_ready && bus_if.mem_req_ready) check("dual_grant", 1, 0);
            if (bus_if.if_req_ready) begin
                if (grant_q.size() == 0) check("grant_if_unexpected", 1, 0);
                else check("grant_order_if", GR_IF, grant_q.pop_front());
            end
            if (bus_if.mem_req_ready) begin
                if (grant_q.size() == 0) check("grant_mem_unexpected", 1, 0);
                else check("grant_order_mem", GR_MEM, grant_q.pop_front());
            end
            if (bus_if.if_resp_valid) begin
                if_beats++;
                if (if_q.size() == 0) check("if_resp_unexpected", 1, 0);
                else begin
                    e = if_q.pop_front();
                    check("if_resp_data", bus_if.if_resp_data, e.data);
                    check("if_resp_last", bus_if.if_resp_last, e.last);
                    check("if_resp_err", bus_if.if_resp_err, e.err);
                end
            end else if (bus_if.if_resp_last || bus_if.if_resp_err) begin
                check("if_idle_flags", {bus_if.if_resp_last, bus_if.if_resp_err}, 0);
            end
            if (bus_if.mem_resp_valid) begin
                if (mem_q.size() == 0) check("mem_resp_unexpected", 1, 0);
                else begin
                    e = mem_q.pop_front();
                    check("mem_resp_data", bus_if.mem_resp_data, e.data);
                    check("mem_resp_last", bus_if.mem_resp_last, e.last);
                    check("mem_resp_err", bus_if.mem_resp_err, e.err);
                end
            end else if (bus_if.mem_resp_last || bus_if.mem_resp_err) begin
                check("mem_idle_flags", {bus_if.mem_resp_last, bus_if.mem_resp_err}, 0);
            end
        end
    end

    task automatic req_if(input logic [63:0] a, input logic [7:0] l, input logic [1:0] s);
        int w = 0;
        bus_if.if_req_valid = 1'b1;
        bus_if.if_req_addr  = a;
        bus_if.if_req_len   = l;
        bus_if.if_req_size  = s;
        @(negedge clk);
        while (!bus_if.if_req_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!bus_if.if_req_ready) check("if_ready_timeout", 0, 1);
        else grant_cyc_if = cyc;
        @(posedge clk);
        #1;
        bus_if.if_req_valid = 1'b0;
        bus_if.if_req_addr  = '0;
        bus_if.if_req_len   = '0;
    endtask

    task automatic req_mem(input logic wr, input logic [63:0] a, input logic [7:0] l,
                           input logic [1:0] s, input logic [63:0] wd);
        int w = 0;
        bus_if.mem_req_valid = 1'b1;
        bus_if.mem_req_wr    = wr;
        bus_if.mem_req_addr  = a;
        bus_if.mem_req_len   = l;
        bus_if.mem_req_size  = s;
        bus_if.mem_req_wdata = wd;
        @(negedge clk);
        while (!bus_if.mem_req_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!bus_if.mem_req_ready) check("mem_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        bus_if.mem_req_valid = 1'b0;
        bus_if.mem_req_addr  = '0;
        bus_if.mem_req_wdata = '0;
    endtask

    // Bridge model: serves n transactions; read data from rtab or addr+beat.
    task automatic bridge_serve(input int n);
        for (int t = 0; t < n; t++) begin
            int w = 0;
            int nb;
            @(negedge clk);
            while (!(bus_if.bus_ar_valid || bus_if.bus_aw_valid) && w < 200) begin
                @(negedge clk);
                w++;
            end
            if (!(bus_if.bus_ar_valid || bus_if.bus_aw_valid)) begin
                check("bridge_valid_timeout", 0, 1);
                return;
            end
            cap_addr = bus_if.bus_addr;
            cap_len  = bus_if.bus_len;
            cap_size = bus_if.bus_size;
            cap_data = bus_if.bus_data;
            cap_cyc  = cyc;
            if (bus_if.bus_ar_valid) begin
                nb = int'(cap_len) + 1;
                @(posedge clk);
                #1 bus_if.bus_ar_ready = 1'b1;
                @(posedge clk);
                #1 bus_if.bus_ar_ready = 1'b0;
                for (int b = 0; b < nb; b++) begin
                    bus_if.bus_r_valid = 1'b1;
                    bus_if.bus_r_data  = (use_tab && b < 4) ? rtab[b] : cap_addr + 64'(b);
                    bus_if.bus_resp    = (b < 16 && err_mask[b]) ? 2'b10 : RESP_OKAY;
                    @(posedge clk);
                    #1;
                    if (!reset_n) break;
                end
                bus_if.bus_r_valid = 1'b0;
                bus_if.bus_r_data  = '0;
                bus_if.bus_resp    = RESP_OKAY;
            end else begin
                repeat (aw_delay) @(posedge clk);
                #1 bus_if.bus_aw_ready = 1'b1;
                @(posedge clk);
                #1 bus_if.bus_aw_ready = 1'b0;
            end
        end
    endtask

    task automatic drain_check(input string tag);
        repeat (2) @(negedge clk);
        check({tag, "_if_q_empty"}, if_q.size(), 0);
        check({tag, "_mem_q_empty"}, mem_q.size(), 0);
        check({tag, "_grant_q_empty"}, grant_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin : main
        int base;
        reset_n = 1'b0;
        bus_if.if_req_valid  = 1'b0;
        bus_if.if_req_addr   = '0;
        bus_if.if_req_len    = '0;
        bus_if.if_req_size   = '0;
        bus_if.mem_req_valid = 1'b0;
        bus_if.mem_req_wr    = 1'b0;
        bus_if.mem_req_addr  = '0;
        bus_if.mem_req_len   = '0;
        bus_if.mem_req_size  = '0;
        bus_if.mem_req_wdata = '0;
        bus_if.bus_ar_ready  = 1'b0;
        bus_if.bus_r_valid   = 1'b0;
        bus_if.bus_r_data    = '0;
        bus_if.bus_resp      = RESP_OKAY;
        bus_if.bus_aw_ready  = 1'b0;
        use_tab  = 1'b0;
        err_mask = '0;
        aw_delay = 5;
        rtab[0] = 64'h11; rtab[1] = 64'h22; rtab[2] = 64'h33; rtab[3] = 64'h44;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ar_valid", bus_if.bus_ar_valid, 0);
        check("rst_aw_valid", bus_if.bus_aw_valid, 0);
        check("rst_bus_addr", bus_if.bus_addr, 0);
        check("rst_bus_len", bus_if.bus_len, 0);
        check("rst_bus_data", bus_if.bus_data, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // IF burst of four table beats
        use_tab = 1'b1;
        grant_q.push_back(GR_IF);
        push_if(64'h11, 0, 0); push_if(64'h22, 0, 0); push_if(64'h33, 0, 0); push_if(64'h44, 1, 0);
        fork
            req_if(64'h8000_0000, 8'd3, SIZE_8B);
            bridge_serve(1);
        join
        check("t1_ar_latency", 64'(cap_cyc - grant_cyc_if), 1);
        check("t1_bus_addr", cap_addr, 64'h8000_0000);
        check("t1_bus_len", cap_len, 3);
        check("t1_bus_size", cap_size, 2'b11);
        drain_check("t1");
        use_tab = 1'b0;

        // Both requesters held continuously: grants alternate M, I, M, I
        grant_q.push_back(GR_MEM); grant_q.push_back(GR_IF);
        grant_q.push_back(GR_MEM); grant_q.push_back(GR_IF);
        push_mem(64'h200, 1, 0);
        push_if(64'h100, 0, 0); push_if(64'h101, 1, 0);
        push_mem(64'h400, 0, 0); push_mem(64'h401, 1, 0);
        push_if(64'h300, 0, 0); push_if(64'h301, 0, 0); push_if(64'h302, 1, 0);
        fork
            begin req_if(64'h100, 8'd1, SIZE_8B); req_if(64'h300, 8'd2, SIZE_8B); end
            begin
                req_mem(1'b0, 64'h200, 8'd0, SIZE_8B, '0);
                req_mem(1'b0, 64'h400, 8'd1, SIZE_8B, '0);
            end
            bridge_serve(4);
        join
        drain_check("t2");

        // MEM write, completion after a five-cycle bridge delay
        grant_q.push_back(GR_MEM);
        push_mem(64'h0, 1, 0);
        fork
            req_mem(1'b1, 64'h8000_1000, 8'd7, SIZE_8B, 64'hDEAD_BEEF_0123_4567);
            bridge_serve(1);
        join
        check("t3_bus_addr", cap_addr, 64'h8000_1000);
        check("t3_bus_len", cap_len, 0);
        check("t3_bus_data", cap_data, 64'hDEAD_BEEF_0123_4567);
        drain_check("t3");

        // MEM read with an error response on the second beat
        err_mask = 16'h0002;
        grant_q.push_back(GR_MEM);
        push_mem(64'h8000_2000, 0, 0); push_mem(64'h8000_2001, 1, 1);
        fork
            req_mem(1'b0, 64'h8000_2000, 8'd1, SIZE_8B, '0);
            bridge_serve(1);
        join
        drain_check("t4");
        err_mask = '0;

        // Reset during IF_R after two of four beats
        use_tab = 1'b1;
        base = if_beats;
        grant_q.push_back(GR_IF);
        push_if(64'h11, 0, 0); push_if(64'h22, 0, 0);
        fork
            req_if(64'h8000_0040, 8'd3, SIZE_8B);
            bridge_serve(1);
            begin
                int w = 0;
                while (if_beats < base + 2 && w < 200) begin
                    @(posedge clk);
                    w++;
                end
                check("t5_beats_before_reset", 64'(if_beats - base), 2);
                #2 reset_n = 1'b0;
                #1;
                check("t5_rst_if_resp_valid", bus_if.if_resp_valid, 0);
                check("t5_rst_ar_valid", bus_if.bus_ar_valid, 0);
                check("t5_rst_bus_addr", bus_if.bus_addr, 0);
                check("t5_rst_bus_len", bus_if.bus_len, 0);
                repeat (2) @(posedge clk);
                @(negedge clk);
                reset_n = 1'b1;
            end
        join
        use_tab = 1'b0;
        drain_check("t5");

        // After reset, simultaneous requests go MEM first
        grant_q.push_back(GR_MEM); grant_q.push_back(GR_IF);
        push_mem(64'h600, 1, 0);
        push_if(64'h500, 1, 0);
        fork
            req_if(64'h500, 8'd0, SIZE_4B);
            req_mem(1'b0, 64'h600, 8'd0, SIZE_4B, '0);
            bridge_serve(2);
        join
        drain_check("t5b");

        // Spurious bridge pulses while idle are ignored
        bus_if.bus_r_valid  = 1'b1;
        bus_if.bus_r_data   = 64'hBAD;
        bus_if.bus_aw_ready = 1'b1;
        bus_if.bus_resp     = 2'b10;
        @(negedge clk);
        check("t6_if_resp_valid", bus_if.if_resp_valid, 0);
        check("t6_mem_resp_valid", bus_if.mem_resp_valid, 0);
        @(posedge clk);
        #1;
        bus_if.bus_r_valid  = 1'b0;
        bus_if.bus_r_data   = '0;
        bus_if.bus_aw_ready = 1'b0;
        bus_if.bus_resp     = RESP_OKAY;
        @(negedge clk);
        check("t6_ar_valid_idle", bus_if.bus_ar_valid, 0);
        check("t6_aw_valid_idle", bus_if.bus_aw_valid, 0);
        grant_q.push_back(GR_MEM);
        push_mem(64'h700, 1, 0);
        @(posedge clk);
        #1;
        bus_if.mem_req_valid = 1'b1;
        bus_if.mem_req_wr    = 1'b0;
        bus_if.mem_req_addr  = 64'h700;
        bus_if.mem_req_len   = 8'd0;
        #1;
        check("t6_still_idle_ready", bus_if.mem_req_ready, 1);
        fork
            req_mem(1'b0, 64'h700, 8'd0, SIZE_8B, '0);
            bridge_serve(1);
        join
        drain_check("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
